// File: rtl/gf571_pkg.sv
// Shared GF(2^571) definitions: field width, reduction polynomial, multiplier latency,
// the arbiter state type, and a bit-serial field multiply used by the multiplier core.
package gf571_pkg;

  localparam int GF571_M        = 571;
  localparam int GF571_MULT_LAT = 3;

  typedef logic [GF571_M-1:0] gf571_t;

  // Low-order terms of x^571 + x^10 + x^5 + x^2 + 1, i.e. what x^571 folds back to.
  localparam gf571_t GF571_POLY = 571'h425;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // MSB-first shift-and-add; each shift folds the overflowing x^571 term back in.
  function automatic gf571_t gf571_mul(input gf571_t a, input gf571_t b);
    gf571_t acc;
    acc = '0;
    for (int i = GF571_M - 1; i >= 0; i--) begin
      acc = {acc[GF571_M-2:0], 1'b0} ^ (acc[GF571_M-1] ? GF571_POLY : '0);
      if (b[i]) acc = acc ^ a;
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2m_mult571.sv
// GF(2^571) multiplier with a fixed LAT-cycle pipeline from registered operands to c.
module gf2m_mult571
  import gf571_pkg::*;
#(
  parameter int LAT = GF571_MULT_LAT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  gf571_t a,
  input  gf571_t b,
  output gf571_t c
);

  gf571_t stage [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) stage[s] <= '0;
    end else begin
      stage[0] <= gf571_mul(a, b);
      for (int s = 1; s < LAT; s++) stage[s] <= stage[s-1];
    end
  end

  assign c = stage[LAT-1];

endmodule

// File: rtl/gf571_rr_pick.sv
// Combinational requester picker: first valid requester searching upward from ptr.
// With GF571_ARB_FIXED_PRIO_EN defined, ptr is ignored and the lowest index wins.
module gf571_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   win_idx
);

`ifdef GF571_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    logic          found;
    logic [PW-1:0] j;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef GF571_ARB_FIXED_PRIO_EN
      j = PW'(k);
`else
      j = PW'((int'(ptr) + k) % NREQ);
`endif
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win_idx  = j;
      end
    end
  end

endmodule

// File: rtl/gf571_mult_arbiter.sv
// Shares one gf2m_mult571 between NREQ requesters with round-robin arbitration.
// Define GF571_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module gf571_mult_arbiter
  import gf571_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MULT_LAT = GF571_MULT_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*571-1:0]   req_a,
  input  logic [NREQ*571-1:0]   req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output gf571_t                rsp_c,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MULT_LAT + 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win_idx;
  logic [NREQ-1:0] grant;
  gf571_t        op_a, op_b, prod;
  logic          accept;

  gf571_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .win_idx   (win_idx)
  );

  gf2m_mult571 #(.LAT(MULT_LAT)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (op_a),
    .b     (op_b),
    .c     (prod)
  );

  assign req_ready = (state == ST_IDLE || state == ST_RESP) ? grant : '0;
  assign accept    = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= '0;
      rsp_c     <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            op_a  <= req_a[int'(win_idx)*GF571_M +: GF571_M];
            op_b  <= req_b[int'(win_idx)*GF571_M +: GF571_M];
            owner <= win_idx;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_BUSY;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // The pipeline output is settled once cnt reaches MULT_LAT.
          if (cnt == CW'(MULT_LAT)) begin
            rsp_c     <= prod;
            rsp_valid <= NREQ'(1) << owner;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GF571_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gf571_mult_arbiter.sv
// Self-checking bench for gf571_mult_arbiter against a carry-less-multiply-then-reduce model.
module tb_gf571_mult_arbiter;
  import gf571_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*571-1:0] req_a = '0;
  logic [NREQ*571-1:0] req_b = '0;
  logic [NREQ-1:0]     rsp_valid;
  gf571_t              rsp_c;
  logic                busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  gf571_mult_arbiter #(.NREQ(NREQ), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_c     (rsp_c),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full 1141-bit carry-less product, then fold every term >= x^571 down.
  function automatic gf571_t ref_mul(input gf571_t a, input gf571_t b);
    logic [1140:0] p;
    logic [1140:0] ax;
    p  = '0;
    ax = {570'b0, a};
    for (int i = 0; i < 571; i++)
      if (b[i]) p = p ^ (ax << i);
    for (int i = 1140; i >= 571; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i - 571] = ~p[i - 571];
        p[i - 569] = ~p[i - 569];
        p[i - 566] = ~p[i - 566];
        p[i - 561] = ~p[i - 561];
      end
    end
    return p[570:0];
  endfunction

  function automatic gf571_t rand571();
    logic [575:0] t;
    for (int w = 0; w < 18; w++) t[w*32 +: 32] = $urandom;
    return t[570:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on requester r and check the response against exp.
  task automatic issue(input string name, input int r, input gf571_t a, input gf571_t b,
                       input gf571_t exp);
    int acc_cyc;
    int got;
    logic [NREQ-1:0] exp_v;
    acc_cyc = -1;
    got     = -1;
    exp_v   = '0;
    exp_v[r] = 1'b1;
    req_a[r*571 +: 571] = a;
    req_b[r*571 +: 571] = b;
    req_valid[r] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        acc_cyc = cyc + 1;
        break;
      end
    end
    tests++;
    if (acc_cyc < 0) begin
      fails++;
      $display("FAIL %s accept: no req_ready within 30 cycles, required ready[%0d]=1", name, r);
      req_valid[r] = 1'b0;
      tick();
      return;
    end
    tick();
    req_valid[r] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = cyc;
        break;
      end
    end
    tests++;
    if (got < 0) begin
      fails++;
      $display("FAIL %s response: no rsp_valid within 20 cycles", name);
      tick();
      return;
    end
    tests++;
    if (rsp_valid !== exp_v) begin
      fails++;
      $display("FAIL %s rsp_valid: got %b required %b", name, rsp_valid, exp_v);
    end
    tests++;
    if (rsp_c !== exp) begin
      fails++;
      $display("FAIL %s rsp_c: got %h required %h", name, rsp_c, exp);
    end
    tests++;
    if (got - acc_cyc !== LAT + 1) begin
      fails++;
      $display("FAIL %s latency: got %0d edges required %0d", name, got - acc_cyc, LAT + 1);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_in_resp: got %b required 1", name, busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      fails++;
      $display("FAIL %s after_resp: busy=%b rsp_valid=%b required 0/0", name, busy, rsp_valid);
    end
    $display("[TB] %s: req %0d accepted edge %0d, response edge %0d, c=%h", name, r, acc_cyc, got, rsp_c);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (rsp_valid !== '0 || rsp_c !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++;
      $display("FAIL reset_state: rsp_valid=%b rsp_c=%h busy=%b ready=%b required all 0",
               rsp_valid, rsp_c, busy, req_ready);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      fails++;
      $display("FAIL post_reset: busy=%b rsp_valid=%b required 0", busy, rsp_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    issue("single", 0, 571'h2, 571'h3, 571'h6);
  endtask

  task automatic test_reduction();
    gf571_t a;
    a = '0;
    a[570] = 1'b1;
    issue("reduction", 0, a, 571'h2, 571'h425);
  endtask

  task automatic test_random();
    gf571_t a, b;
    int r;
    for (int n = 0; n < 8; n++) begin
      a = rand571();
      b = rand571();
      if (n == 0) b = '1;
      r = $urandom_range(0, NREQ - 1);
      issue("random", r, a, b, ref_mul(a, b));
    end
  endtask

  task automatic test_contention();
    int acc_idx[$];
    int acc_edge[$];
    int rsp_cyc[$];
    logic [NREQ-1:0] rsp_v[$];
    gf571_t rsp_val[$];
    int mptr;
    int w;
    logic [NREQ-1:0] ev;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_a[0 +: 571]   = 571'h2;
    req_b[0 +: 571]   = 571'h2;
    req_a[571 +: 571] = 571'h3;
    req_b[571 +: 571] = 571'h3;
    req_valid = '1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        acc_idx.push_back(req_ready[1] ? 1 : 0);
        acc_edge.push_back(cyc + 1);
      end
      if (rsp_valid != '0) begin
        rsp_cyc.push_back(cyc);
        rsp_v.push_back(rsp_valid);
        rsp_val.push_back(rsp_c);
      end
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    tests++;
    if (acc_idx.size() < 4 || rsp_cyc.size() < 4) begin
      fails++;
      $display("FAIL contention_count: accepts %0d responses %0d required >=4 each",
               acc_idx.size(), rsp_cyc.size());
      return;
    end
    mptr = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef GF571_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = mptr;
      mptr = (w + 1) % NREQ;
`endif
      ev = '0;
      ev[w] = 1'b1;
      tests++;
      if (acc_idx[i] !== w) begin
        fails++;
        $display("FAIL contention_grant%0d: got req %0d required req %0d", i, acc_idx[i], w);
      end
      if (i > 0) begin
        tests++;
        if (acc_edge[i] - acc_edge[i-1] !== LAT + 2) begin
          fails++;
          $display("FAIL contention_spacing%0d: got %0d cycles required %0d", i,
                   acc_edge[i] - acc_edge[i-1], LAT + 2);
        end
      end
      tests++;
      if (rsp_cyc[i] !== acc_edge[i] + LAT + 1 || rsp_v[i] !== ev ||
          rsp_val[i] !== (w == 0 ? 571'h4 : 571'h5)) begin
        fails++;
        $display("FAIL contention_rsp%0d: edge %0d valid %b c=%h required edge %0d valid %b c=%0d",
                 i, rsp_cyc[i], rsp_v[i], rsp_val[i], acc_edge[i] + LAT + 1, ev, (w == 0 ? 4 : 5));
      end
      $display("[TB] contention: accept %0d to req %0d at edge %0d, c=%h", i, acc_idx[i],
               acc_edge[i], rsp_val[i]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic ok;
    req_a[0 +: 571] = 571'h9;
    req_b[0 +: 571] = 571'h9;
    req_valid = 2'b01;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid = '0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_mid_accept: no accept of req 0");
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_inflight: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== '0 || rsp_c !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: rsp_valid=%b rsp_c=%h busy=%b ready=%b required all 0",
               rsp_valid, rsp_c, busy, req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_mid_no_rsp: activity seen after reset release, required none");
    end
    tick();
    // Both requesters valid: a reset pointer must favour requester 0.
    req_a[0 +: 571]   = 571'h5;
    req_b[0 +: 571]   = 571'h7;
    req_a[571 +: 571] = 571'h3;
    req_b[571 +: 571] = 571'h3;
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_ptr: ready=%b required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    issue("post_reset", 0, 571'h5, 571'h7, 571'h1b);
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle: %0d of 20 cycles had nonzero ready/rsp_valid/busy, required 0", bad);
    end
    $display("[TB] idle: 20 cycles checked");
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reduction();
    test_random();
    test_contention();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
